voting_machine: RTL and testbench

//   Three-candidate vote counter for a simple ballot front end. Each press of a

---
 rtl/voting_pkg.sv | 23 ++
 rtl/vote_counter.sv | 28 ++
 rtl/voting_machine.sv | 96 +++++++++
 tb/tb_voting_machine.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/voting_pkg.sv
// Shared definitions for the three-candidate voting machine.
package voting_pkg;

    localparam int CNT_W_DEF = 6;
    localparam int NUM_CAND  = 3;
    localparam int CNT_MAX   = 2**CNT_W_DEF - 1;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_CLOSED = 1'b1
    } state_t;

    // True when exactly one bit of the press vector is set.
    function automatic logic is_onehot(input logic [NUM_CAND-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_CAND; i++) begin
            n = n + int'(v[i]);
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/vote_counter.sv
// Saturating up-counter with enable; clears asynchronously on reset.
module vote_counter
    import voting_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    logic [CNT_W-1:0] r_cnt;

    // Count enabled votes, holding at the maximum instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != MAX_VAL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/voting_machine.sv
// Three-candidate vote counter: press detection, single-press acceptance,
// open/closed ballot FSM and registered result outputs (zero while open).
module voting_machine
    import voting_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_candidate_1,
    input  logic             i_candidate_2,
    input  logic             i_candidate_3,
    input  logic             i_voting_over,
    output logic [CNT_W-1:0] o_count1,
    output logic [CNT_W-1:0] o_count2,
    output logic [CNT_W-1:0] o_count3
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_CAND-1:0]   r_hist;
    logic [NUM_CAND-1:0]   w_btn;
    logic [NUM_CAND-1:0]   w_press;
    logic                  w_accept;
    logic [NUM_CAND-1:0]   w_en;
    logic [CNT_W-1:0]      w_cnt   [NUM_CAND];
    logic [CNT_W-1:0]      r_count [NUM_CAND];

    assign w_btn   = {i_candidate_3, i_candidate_2, i_candidate_1};
    assign w_press = w_btn & ~r_hist;

    // Votes count only while the ballot stays open across this edge; a press
    // coinciding with the close request loses to the close.
    assign w_accept = (r_state == ST_OPEN) && (w_state_nxt == ST_OPEN) && is_onehot(w_press);
    assign w_en     = w_accept ? w_press : '0;

    // Button history, sampled every cycle regardless of ballot state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
        end else begin
            r_hist <= w_btn;
        end
    end

    // Ballot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_OPEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: OPEN closes on the request, CLOSED is sticky.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OPEN:   if (i_voting_over) w_state_nxt = ST_CLOSED;
            ST_CLOSED: w_state_nxt = ST_CLOSED;
            default:   w_state_nxt = ST_OPEN;
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CAND; g++) begin : g_cnt
            vote_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .i_en  (w_en[g]),
                .o_cnt (w_cnt[g])
            );
        end
    endgenerate

    // Results become visible from the closing edge onward; zero while open.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CAND; i++) begin
                r_count[i] <= (w_state_nxt == ST_CLOSED) ? w_cnt[i] : '0;
            end
        end
    end

    assign o_count1 = r_count[0];
    assign o_count2 = r_count[1];
    assign o_count3 = r_count[2];

endmodule

// File: tb/tb_voting_machine.sv
// Directed bench for voting_machine: table-driven cycles plus hand sequences.
`timescale 1ns/1ps
module tb_voting_machine;

    logic       clk;
    logic       rst;
    logic       c1, c2, c3, ov;
    logic [5:0] q1, q2, q3;

    int n_pass;
    int n_total;

    typedef struct {
        logic       c1, c2, c3, ov;
        logic [5:0] e1, e2, e3;
    } vec_t;

    vec_t tbl[$];

    voting_machine #(.CNT_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_candidate_1 (c1),
        .i_candidate_2 (c2),
        .i_candidate_3 (c3),
        .i_voting_over (ov),
        .o_count1      (q1),
        .o_count2      (q2),
        .o_count3      (q3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] e1, input logic [5:0] e2,
                         input logic [5:0] e3);
        n_total++;
        if (q1 === e1 && q2 === e2 && q3 === e3) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d,%0d,%0d expected %0d,%0d,%0d",
                     name, q1, q2, q3, e1, e2, e3);
        end
    endtask

    // Drive one cycle on the falling edge, then sample just after the rising edge.
    task automatic step(input logic b1, input logic b2, input logic b3, input logic o);
        @(negedge clk);
        c1 = b1; c2 = b2; c3 = b3; ov = o;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic b1, input logic b2, input logic b3, input logic o,
                       input logic [5:0] e1, input logic [5:0] e2, input logic [5:0] e3);
        vec_t v;
        v.c1 = b1; v.c2 = b2; v.c3 = b3; v.ov = o;
        v.e1 = e1; v.e2 = e2; v.e3 = e3;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].c1, tbl[i].c2, tbl[i].c3, tbl[i].ov);
            check($sformatf("%s[%0d]", name, i), tbl[i].e1, tbl[i].e2, tbl[i].e3);
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; c1 = 0; c2 = 0; c3 = 0; ov = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; c1 = 0; c2 = 0; c3 = 0; ov = 0;

        // 1. Reset and idle
        repeat (2) @(posedge clk);
        #1;
        check("reset", 6'd0, 6'd0, 6'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            check($sformatf("idle[%0d]", i), 6'd0, 6'd0, 6'd0);
        end

        // 2. Sequence of single pulses, then close -> 3,3,2
        add(1,0,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
        add(0,1,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
        add(1,0,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
        add(0,0,1,0, 0,0,0); add(0,0,0,0, 0,0,0);
        add(0,1,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
        add(0,1,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
        add(1,0,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
        add(0,0,1,0, 0,0,0); add(0,0,0,0, 0,0,0);
        add(0,0,0,1, 3,3,2); add(0,0,0,1, 3,3,2);
        add(0,0,0,0, 3,3,2);
        run_table("seq");

        // 3. Held button counts once
        do_reset();
        for (int i = 0; i < 8; i++) add(0,1,0,0, 0,0,0);
        add(0,0,0,0, 0,0,0);
        add(0,0,0,1, 0,1,0);
        run_table("hold");

        // 4. Simultaneous press discarded; press on closing edge discarded
        do_reset();
        add(1,0,1,0, 0,0,0); add(0,0,0,0, 0,0,0);
        add(1,0,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
        add(0,0,1,1, 1,0,0); add(0,0,0,1, 1,0,0);
        run_table("multi");

        // 5. Saturation at 63, ignored presses after close, drop close request
        do_reset();
        for (int i = 0; i < 70; i++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        check("sat_open", 6'd0, 6'd0, 6'd0);
        step(0, 0, 0, 1);
        check("sat_close", 6'd63, 6'd0, 6'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1);
            step(0, 0, 0, 1);
        end
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        check("after_close", 6'd63, 6'd0, 6'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("ov_drop", 6'd63, 6'd0, 6'd0);

        // 6. Asynchronous reset clears outputs before the next edge
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 6'd0, 6'd0, 6'd0);
        @(negedge clk);
        rst = 1'b0;
        add(0,1,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
        add(0,0,0,1, 0,1,0);
        run_table("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
